// File: rtl/byte_reg_sequencer.sv
// Round-robin front end that turns requester commands into single-cycle
// load/inc/rotate strobes on one shared byte register and returns the result.
module byte_reg_sequencer #(
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic              reg_load,
  output logic              reg_inc,
  output logic              reg_rotate_right,
  output logic [7:0]        reg_d,
  input  logic [7:0]        reg_q
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {OP_READ = 2'b00, OP_LOAD = 2'b01, OP_INC = 2'b10, OP_ROR = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] rr;
  logic [IW-1:0] cur_id;
  op_t           cur_op;
  logic [7:0]    cur_data;
  logic [CW-1:0] cnt;

  logic          gnt_found;
  logic [IW-1:0] gnt_id;
  logic [1:0]    acc_op;
  logic [7:0]    acc_data;
  logic          accept;

  // Circular search for the first valid requester starting at rr.
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[IW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = IW'(idx);
      end
    end
  end

  always_comb begin
    acc_op   = 2'b00;
    acc_data = 8'h00;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == gnt_id) begin
        acc_op   = req_op[2*i +: 2];
        acc_data = req_data[8*i +: 8];
      end
    end
  end

  assign accept = (state == IDLE) && !reset && gnt_found;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (op_t'(acc_op) == OP_READ) ? RESP : EXEC;
      EXEC:    if (cnt == CW'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured command and remaining strobe count; rr advances past the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr       <= '0;
      cur_id   <= '0;
      cur_op   <= OP_READ;
      cur_data <= 8'h00;
      cnt      <= '0;
    end else if (accept) begin
      cur_id   <= gnt_id;
      cur_op   <= op_t'(acc_op);
      cur_data <= acc_data;
      cnt      <= (op_t'(acc_op) == OP_LOAD) ? CW'(1) : CW'(acc_data[2:0]) + CW'(1);
      rr       <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
    end else if (state == EXEC) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    req_ready        = '0;
    rsp_valid        = '0;
    rsp_data         = 8'h00;
    busy             = 1'b0;
    reg_load         = 1'b0;
    reg_inc          = 1'b0;
    reg_rotate_right = 1'b0;
    reg_d            = 8'h00;
    if (accept) req_ready[gnt_id] = 1'b1;
    case (state)
      EXEC: begin
        busy = 1'b1;
        case (cur_op)
          OP_LOAD: begin
            reg_load = 1'b1;
            reg_d    = cur_data;
          end
          OP_INC:  reg_inc = 1'b1;
          OP_ROR:  reg_rotate_right = 1'b1;
          default: ;
        endcase
      end
      RESP: begin
        busy              = 1'b1;
        rsp_valid[cur_id] = 1'b1;
        rsp_data          = reg_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_byte_reg_sequencer.sv
// Bench for byte_reg_sequencer: behavioural byte register plus a transaction-level
// reference model for grant order, strobe counts and returned values.
module tb_byte_reg_sequencer;

  localparam int unsigned NREQ = 4;
  localparam logic [1:0] READ = 2'b00, LOAD = 2'b01, INC = 2'b10, ROR = 2'b11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              busy;
  logic              reg_load;
  logic              reg_inc;
  logic              reg_rotate_right;
  logic [7:0]        reg_d;
  logic [7:0]        reg_q;
  logic [7:0]        breg = 8'h00;

  int compared = 0;
  int mismatched = 0;
  int model_rr = 0;
  logic [7:0] model_q = 8'h00;
  logic [1:0] b_op [4];
  logic [7:0] b_dat [4];

  always #5 clk = ~clk;

  byte_reg_sequencer #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .reg_load(reg_load), .reg_inc(reg_inc), .reg_rotate_right(reg_rotate_right),
    .reg_d(reg_d), .reg_q(reg_q)
  );

  // Shared byte register; its own reset is held inactive throughout.
  always @(posedge clk) begin
    if (reg_load)              breg <= reg_d;
    else if (reg_inc)          breg <= breg + 8'd1;
    else if (reg_rotate_right) breg <= {breg[0], breg[7:1]};
  end
  assign reg_q = breg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] apply(input logic [7:0] q, input logic [1:0] op, input logic [7:0] d);
    int n;
    int r;
    n = int'(d[2:0]) + 1;
    r = n % 8;
    case (op)
      LOAD:    return d;
      INC:     return 8'((int'(q) + n) % 256);
      ROR:     return 8'(((int'(q) >> r) | (int'(q) << (8 - r))) & 255);
      default: return q;
    endcase
  endfunction

  function automatic int pick(input int rr, input logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      if (mask[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  function automatic logic [2:0] strobe_of(input logic [1:0] op);
    case (op)
      LOAD:    return 3'b100;
      INC:     return 3'b010;
      ROR:     return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic drive(input logic [3:0] mask);
    req_valid = mask;
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2]  = b_op[i];
      req_data[8*i +: 8] = b_dat[i];
    end
  endtask

  // Hold every requester in mask valid until each has been served once.
  task automatic serve(input logic [3:0] mask_in);
    logic [3:0] mask;
    logic [7:0] expq;
    int g;
    int n;
    mask = mask_in;
    while (mask != 4'b0000) begin
      @(negedge clk); drive(mask); #1;
      g = pick(model_rr, mask);
      check("grant", 32'(req_ready), 32'(1) << g);
      check("idle_quiet", 32'({busy, reg_load, reg_inc, reg_rotate_right, rsp_valid, rsp_data, reg_d}), 32'(0));
      @(posedge clk);
      model_rr = (g + 1) % 4;
      mask[g] = 1'b0;
      n = (b_op[g] == READ) ? 0 : (b_op[g] == LOAD) ? 1 : int'(b_dat[g][2:0]) + 1;
      expq = apply(model_q, b_op[g], b_dat[g]);
      for (int s = 0; s < n; s++) begin
        @(negedge clk); drive(mask); #1;
        check("exec_strobe", 32'({reg_load, reg_inc, reg_rotate_right}), 32'(strobe_of(b_op[g])));
        check("exec_excl", 32'($countones({reg_load, reg_inc, reg_rotate_right}) <= 1), 32'(1));
        check("exec_reg_d", 32'(reg_d), (b_op[g] == LOAD) ? 32'(b_dat[g]) : 32'(0));
        check("exec_busy_ready_rsp", 32'({busy, req_ready, rsp_valid, rsp_data}), 32'({1'b1, 16'h0000}));
        @(posedge clk);
      end
      @(negedge clk); drive(mask); #1;
      check("rsp_valid", 32'(rsp_valid), 32'(1) << g);
      check("rsp_data", 32'(rsp_data), 32'(expq));
      check("rsp_busy_ready_strobe", 32'({busy, req_ready, reg_load, reg_inc, reg_rotate_right, reg_d}), 32'({1'b1, 15'h0000}));
      model_q = expq;
      @(posedge clk);
    end
    @(negedge clk); req_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      b_op[i]  = READ;
      b_dat[i] = 8'h00;
    end
    // Reset with every requester valid: nothing may be granted.
    @(negedge clk); drive(4'b1111); #1;
    check("reset_ready", 32'(req_ready), 32'(0));
    @(negedge clk); #1;
    check("reset_outputs", 32'({busy, reg_load, reg_inc, reg_rotate_right, rsp_valid, rsp_data, reg_d}), 32'(0));
    reset = 1'b0; req_valid = '0; #1;
    check("post_reset_outputs", 32'({req_ready, busy, reg_load, reg_inc, reg_rotate_right, rsp_valid, rsp_data}), 32'(0));
    model_rr = 0;

    b_op[0] = LOAD; b_dat[0] = 8'hA5; serve(4'b0001);
    b_op[1] = INC;  b_dat[1] = 8'h01; serve(4'b0010);
    b_op[2] = LOAD; b_dat[2] = 8'hA6; serve(4'b0100);
    b_op[3] = ROR;  b_dat[3] = 8'h00; serve(4'b1000);
    b_op[0] = LOAD; b_dat[0] = 8'hFF; serve(4'b0001);
    b_op[1] = INC;  b_dat[1] = 8'h01; serve(4'b0010);
    b_op[2] = ROR;  b_dat[2] = 8'h07; serve(4'b0100);

    // Round-robin after reset.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; model_rr = 0;
    for (int i = 0; i < 4; i++) b_op[i] = READ;
    serve(4'b1111);
    serve(4'b0011);
    serve(4'b1001);

    // Reset in the middle of an INC x8.
    b_op[0] = LOAD; b_dat[0] = 8'h10; serve(4'b0001);
    b_op[1] = INC;  b_dat[1] = 8'h07;
    @(negedge clk); drive(4'b0010); #1;
    check("mid_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk);
    @(negedge clk); req_valid = '0; #1;
    check("mid_inc1", 32'({reg_load, reg_inc, reg_rotate_right}), 32'(3'b010));
    @(negedge clk); #1;
    check("mid_inc2", 32'({reg_load, reg_inc, reg_rotate_right}), 32'(3'b010));
    @(negedge clk); reset = 1'b1; drive(4'b0101); #1;
    check("mid_inc3", 32'({reg_load, reg_inc, reg_rotate_right}), 32'(3'b010));
    check("mid_ready_in_reset", 32'(req_ready), 32'(0));
    @(negedge clk); #1;
    check("mid_after_reset", 32'({req_ready, busy, reg_load, reg_inc, reg_rotate_right, rsp_valid, rsp_data}), 32'(0));
    reset = 1'b0; req_valid = '0; #1;
    check("mid_no_rsp", 32'({busy, reg_load, reg_inc, reg_rotate_right, rsp_valid}), 32'(0));
    model_rr = 0;
    model_q = model_q + 8'd3;
    check("mid_reg_value", 32'(breg), 32'(model_q));
    b_op[0] = READ; b_op[2] = READ;
    serve(4'b0101);

    // Random command streams.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        b_op[i]  = 2'($urandom_range(0, 3));
        b_dat[i] = 8'($urandom);
      end
      serve(4'($urandom_range(1, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/byte_reg_sequencer.md
# byte_reg_sequencer

Controller that shares one `byte_register` instance between `NREQ` requesters. It round-robin arbitrates among the requesters and executes each accepted command as a sequence of single-cycle `load`/`inc`/`rotate_right` strobes. It then returns the resulting register value to the requester that issued the command. It sits between the requesting units and the register's control pins, and is the only agent that drives those pins.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: reset, synchronous, active-high. The top level ties the register's `reset_n` to `~reset`.
- `req_valid` in NREQ: per-requester command valid.
- `req_ready` out NREQ: per-requester accept. At most one bit is high.
- `req_op` in 2*NREQ: per-requester op, slice i = [2i+1:2i]. Encoding: 00 READ, 01 LOAD, 10 INC, 11 ROR.
- `req_data` in 8*NREQ: per-requester operand, slice i = [8i+7:8i]. LOAD uses it as the value. INC/ROR use bits [2:0] as a repeat count minus 1.
- `rsp_valid` out NREQ: one-hot, single-cycle completion pulse to the owning requester.
- `rsp_data` out 8: register value at completion. Valid only while `rsp_valid` is nonzero, otherwise 0.
- `busy` out 1: high in EXEC and RESP.
- `reg_load`, `reg_inc`, `reg_rotate_right` out 1 each: register control strobes.
- `reg_d` out 8: register data input.
- `reg_q` in 8: register output.

## Operation
- **States.**
  - IDLE: no command owned.
  - EXEC: issuing strobes.
  - RESP: returning the result.
- **Arbitration, IDLE only.**
  - Grant goes to the first requester with `req_valid` set, searching circularly from pointer `rr`.
  - `req_ready[grant]` is asserted combinationally in the same cycle.
  - Transfer happens when valid and ready are both high. On transfer the block captures id, op and operand, and sets `rr` = (id+1) mod NREQ.
- **Requester rules.** Op and data are held stable while valid is high and unaccepted. Dropping valid before accept is legal and has no effect.
- **Transitions.**
  - IDLE → EXEC on accept of LOAD/INC/ROR, with remaining count `cnt` = 1 for LOAD, or operand[2:0]+1 for INC/ROR (range 1..8).
  - IDLE → RESP on accept of READ.
  - EXEC: each cycle asserts exactly one strobe matching the op and decrements `cnt`. When `cnt` reaches 1 in that cycle, go to RESP.
  - RESP: `rsp_valid[id]`=1 and `rsp_data`=`reg_q` for one cycle, then IDLE. No request is accepted in RESP.
- **Strobes.**
  - Strobes are mutually exclusive. The controller never depends on the register's internal priority.
  - `reg_d` = captured operand while `reg_load` is high, 0 otherwise.
- **Arithmetic.** INC wraps modulo 256 (0xFF+1 = 0x00). ROR count 8 returns the original value.
- **Reset** (sampled high at an edge):
  - Next state is IDLE, `rr`=0, and all outputs are 0 after that edge.
  - A command in flight is abandoned with no `rsp_valid`. Strobes already issued are not undone.
  - `req_ready` is forced 0 while `reset` is high.

## Timing
- Command accepted in cycle T. N = strobe count.
- Strobes occur in cycles T+1..T+N. The register updates at the rising edge ending each strobe cycle.
- Response timing:
  - LOAD/INC/ROR: `rsp_valid` at T+N+1.
  - READ: `rsp_valid` at T+1.
- The next accept can occur no earlier than T+N+2 (T+2 for READ).
- `rsp_data` equals the register value after the final strobe's update.
- After reset, requester 0 has highest priority.
- Fairness: a continuously requesting requester waits at most NREQ-1 other commands.
- All outputs are 0 from reset until the first accept.

## Test plan
- **Reset, then LOAD.** Reset, then requester 0 LOAD 0xA5 → `req_ready[0]` at T, `reg_load`=1 with `reg_d`=0xA5 at T+1 only, `rsp_valid`=0001 and `rsp_data`=0xA5 at T+2.
- **INC ×2.** Requester 1 INC, data=0x01, with Q=0xA5 → `reg_inc` high for T+1..T+2, `rsp_valid`=0010 and `rsp_data`=0xA7 at T+3.
- **ROR ×1 and wrap.**
  - ROR ×1, data=0x00, on 0xA6 → `rsp_data`=0x53.
  - INC ×2 on 0xFF → `rsp_data`=0x01.
- **Round-robin.** All four requesters READ simultaneously after reset → accepts in order 0,1,2,3, each `rsp_valid` at accept+1. A repeat with `rr`=2 and requesters 0 and 3 valid → grants go to 3, then 0.
- **Reset mid-EXEC.** LOAD 0x10, then INC ×8, with `reset` asserted after 3 `reg_inc` cycles → strobes 0 after that edge, no `rsp_valid`, Q=0x13 (register reset deasserted for the check). Next request from requesters 0 and 2 is granted to 0.
- **Strobe exclusivity.** Across random op/operand streams, at most one strobe is high each cycle and `busy` matches EXEC/RESP.
